// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage (PC, imem handshake, 1-entry fetch buffer) plus IF/ID pipeline register.
// Latency: imem_rdy in the cycle after launch lands in IF/ID at the next edge; 1 instr/cycle sustained.
// Backpressure: IF_IDWr=0 parks one response in the fetch buffer; no new launch until it has room.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   PCWr, IF_IDWr            hazard-unit enables (new fetch / IF/ID load)
//   IF_IDFlush               squash IF/ID contents (taken branch/jump)
//   redirect, redirect_pc    load PC with a branch/jump target
//   imem_req/addr/rdy/rdata  instruction memory request/ready handshake
//   IF_ID_Instr/PC4/Valid    IF/ID register contents to ID
//   IF_ID_Rs, IF_ID_Rt       register fields of IF_ID_Instr, back to the hazard unit
// Optional: define IF_PERF_CNT_EN to add perf_fetched / perf_squashed counters.

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWr,
  input  logic        IF_IDWr,
  input  logic        IF_IDFlush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic [4:0]  IF_ID_Rs,
  output logic [4:0]  IF_ID_Rt
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        kill;
  logic        fb_valid;
  logic [31:0] fb_instr;
  logic [31:0] fb_pc4;

  logic resp;         // response completes this cycle
  logic resp_drop;    // response belongs to a squashed fetch
  logic resp_keep;
  logic ifid_load;    // IF/ID takes new contents (not flushed)
  logic fb_drain;
  logic resp_direct;  // response bypasses the fetch buffer
  logic resp_to_fb;
  logic fb_valid_nxt;
  logic launch;

  assign resp        = (state == S_BUSY) && imem_rdy;
  assign resp_drop   = resp && (kill || redirect);
  assign resp_keep   = resp && !resp_drop;
  assign ifid_load   = IF_IDWr && !IF_IDFlush;
  assign fb_drain    = ifid_load && fb_valid;
  assign resp_direct = resp_keep && ifid_load && !fb_valid;
  assign resp_to_fb  = resp_keep && !resp_direct;

  // Redirect discards any buffered instruction; a kept response can never
  // coincide with a redirect, so the priority order is unambiguous.
  always_comb begin
    fb_valid_nxt = fb_valid;
    if (redirect)
      fb_valid_nxt = 1'b0;
    else if (resp_to_fb)
      fb_valid_nxt = 1'b1;
    else if (fb_drain)
      fb_valid_nxt = 1'b0;
  end

  // A launch needs the buffer to be empty after this edge: IF/ID plus the
  // buffer are the only places an instruction can wait, so this keeps at
  // most two instructions in flight and a response always has a home.
  // Launches happen from idle or back-to-back in the response cycle.
  assign launch = PCWr && !redirect && !fb_valid_nxt &&
                  ((state == S_IDLE) || resp);

  assign imem_addr = req_addr;
  assign IF_ID_Rs  = IF_ID_Instr[25:21];
  assign IF_ID_Rt  = IF_ID_Instr[20:16];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      req_addr    <= 32'd0;
      kill        <= 1'b0;
      fb_valid    <= 1'b0;
      fb_instr    <= 32'd0;
      fb_pc4      <= 32'd0;
      IF_ID_Instr <= 32'd0;
      IF_ID_PC4   <= 32'd0;
      IF_ID_Valid <= 1'b0;
    end else begin
      // PC: redirect overrides the sequential increment
      if (redirect)
        pc <= redirect_pc;
      else if (launch)
        pc <= pc + 32'd4;

      if (launch)
        req_addr <= pc;

      // Request FSM; imem_req mirrors S_BUSY as a registered output
      if (state == S_IDLE) begin
        if (launch) begin
          state    <= S_BUSY;
          imem_req <= 1'b1;
        end
      end else begin
        if (resp && !launch) begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      end

      // The outstanding request cannot be withdrawn, so a redirect while it
      // is still pending marks its eventual response for discard.
      if (resp)
        kill <= 1'b0;
      else if (redirect && (state == S_BUSY))
        kill <= 1'b1;

      fb_valid <= fb_valid_nxt;
      if (resp_to_fb) begin
        fb_instr <= imem_rdata;
        fb_pc4   <= req_addr + 32'd4;
      end

      // IF/ID: flush applies even when IF_IDWr=0
      if (IF_IDFlush) begin
        IF_ID_Instr <= 32'd0;
        IF_ID_PC4   <= 32'd0;
        IF_ID_Valid <= 1'b0;
      end else if (IF_IDWr) begin
        if (fb_valid) begin
          IF_ID_Instr <= fb_instr;
          IF_ID_PC4   <= fb_pc4;
          IF_ID_Valid <= 1'b1;
        end else if (resp_direct) begin
          IF_ID_Instr <= imem_rdata;
          IF_ID_PC4   <= req_addr + 32'd4;
          IF_ID_Valid <= 1'b1;
        end else begin
          // bubble: PC4 deliberately holds
          IF_ID_Instr <= 32'd0;
          IF_ID_Valid <= 1'b0;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic flush_valid;
  assign flush_valid = IF_IDFlush && IF_ID_Valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched  <= 32'd0;
      perf_squashed <= 32'd0;
    end else begin
      perf_fetched  <= perf_fetched + {31'd0, resp_keep};
      perf_squashed <= perf_squashed + {31'd0, resp_drop} + {31'd0, flush_valid};
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWr, IF_IDWr, IF_IDFlush, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_Instr, IF_ID_PC4;
  logic        IF_ID_Valid;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .PCWr(PCWr), .IF_IDWr(IF_IDWr),
    .IF_IDFlush(IF_IDFlush), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_rdata(imem_rdata), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: answers each request with imem_rdata = address after a
  // fixed (or random, up to mem_delay) number of wait cycles.
  int          mem_delay   = 0;
  bit          mem_rand    = 1'b0;
  bit          mem_pending = 1'b0;
  int          mem_cnt     = 0;
  bit          force_rdy   = 1'b0;
  logic        prev_req, prev_rdy;
  logic [31:0] prev_addr;

  task automatic step();
    @(negedge clk);
    prev_req  = imem_req;
    prev_addr = imem_addr;
    if (force_rdy) begin
      imem_rdy    = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      mem_pending = 1'b0;
    end else if (imem_req) begin
      if (!mem_pending) begin
        mem_pending = 1'b1;
        mem_cnt = mem_rand ? int'($urandom_range(0, mem_delay)) : mem_delay;
      end
      if (mem_cnt == 0) begin
        imem_rdy    = 1'b1;
        imem_rdata  = imem_addr;
        mem_pending = 1'b0;
      end else begin
        imem_rdy   = 1'b0;
        imem_rdata = $urandom;
        mem_cnt--;
      end
    end else begin
      imem_rdy    = 1'b0;
      imem_rdata  = $urandom;
      mem_pending = 1'b0;
    end
    prev_rdy = imem_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; PCWr = 1'b1; IF_IDWr = 1'b1; IF_IDFlush = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0; force_rdy = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    n_tests++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", IF_ID_Valid); end
    n_tests++; if (IF_ID_Instr !== 32'd0 || IF_ID_PC4 !== 32'd0) begin n_fail++; $display("FAIL reset_ifid instr=%h pc4=%h exp=0/0", IF_ID_Instr, IF_ID_PC4); end
    n_tests++; if (IF_ID_Rs !== 5'd0 || IF_ID_Rt !== 5'd0) begin n_fail++; $display("FAIL reset_rsrt rs=%0d rt=%0d exp=0/0", IF_ID_Rs, IF_ID_Rt); end
    step();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_first_fetch req=%0b addr=%h exp=1/00003000", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    mem_delay = 0; mem_rand = 1'b0;
    apply_reset();
    step();
    n_tests++; if (IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid got=%0b exp=0", IF_ID_Valid); end
    for (int k = 0; k < 8; k++) begin
      step();
      ea = 32'h3000 + 32'(4 * k);
      n_tests++;
      if (IF_ID_Valid !== 1'b1 || IF_ID_Instr !== ea || IF_ID_PC4 !== ea + 32'd4 ||
          IF_ID_Rs !== ea[25:21] || IF_ID_Rt !== ea[20:16] || imem_addr !== ea + 32'd4) begin
        n_fail++;
        $display("FAIL stream_%0d valid=%0b instr=%h pc4=%h addr=%h exp=1/%h/%h/%h",
                 k, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4, imem_addr, ea, ea + 32'd4, ea + 32'd4);
      end
    end
  endtask

  task automatic test_load_use();
    mem_delay = 0; mem_rand = 1'b0;
    apply_reset();
    step(); step(); step();
    n_tests++; if (IF_ID_PC4 !== 32'h3008) begin n_fail++; $display("FAIL lu_setup pc4=%h exp=00003008", IF_ID_PC4); end
    PCWr = 1'b0; IF_IDWr = 1'b0;
    step();
    n_tests++; if (IF_ID_PC4 !== 32'h3008 || IF_ID_Valid !== 1'b1 || IF_ID_Instr !== 32'h3004) begin n_fail++; $display("FAIL lu_hold pc4=%h valid=%0b instr=%h exp=00003008/1/00003004", IF_ID_PC4, IF_ID_Valid, IF_ID_Instr); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL lu_no_launch req=%0b exp=0", imem_req); end
    PCWr = 1'b1; IF_IDWr = 1'b1;
    step();
    n_tests++; if (IF_ID_PC4 !== 32'h300C || IF_ID_Instr !== 32'h3008 || IF_ID_Valid !== 1'b1) begin n_fail++; $display("FAIL lu_release pc4=%h instr=%h valid=%0b exp=0000300c/00003008/1", IF_ID_PC4, IF_ID_Instr, IF_ID_Valid); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h300C) begin n_fail++; $display("FAIL lu_relaunch req=%0b addr=%h exp=1/0000300c", imem_req, imem_addr); end
    step();
    n_tests++; if (IF_ID_PC4 !== 32'h3010 || IF_ID_Valid !== 1'b1) begin n_fail++; $display("FAIL lu_next pc4=%h valid=%0b exp=00003010/1", IF_ID_PC4, IF_ID_Valid); end
  endtask

  task automatic test_redirect_busy();
    mem_delay = 3; mem_rand = 1'b0;
    apply_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h4000; IF_IDFlush = 1'b1;
    step();
    redirect = 1'b0; IF_IDFlush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || IF_ID_Valid !== 1'b0) begin
        n_fail++; $display("FAIL rb_stable_%0d req=%0b addr=%h valid=%0b exp=1/00003000/0", i, imem_req, imem_addr, IF_ID_Valid);
      end
      step();
    end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000 || IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL rb_newaddr req=%0b addr=%h valid=%0b exp=1/00004000/0", imem_req, imem_addr, IF_ID_Valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (IF_ID_Valid !== (i == 3)) begin n_fail++; $display("FAIL rb_wait_%0d valid=%0b exp=%0b", i, IF_ID_Valid, (i == 3)); end
    end
    n_tests++; if (IF_ID_PC4 !== 32'h4004 || IF_ID_Instr !== 32'h4000) begin n_fail++; $display("FAIL rb_arrive pc4=%h instr=%h exp=00004004/00004000", IF_ID_PC4, IF_ID_Instr); end
  endtask

  task automatic test_redirect_rdy();
    mem_delay = 0; mem_rand = 1'b0;
    apply_reset();
    step();
    redirect = 1'b1; redirect_pc = 32'h5000; IF_IDFlush = 1'b1;
    step();
    redirect = 1'b0; IF_IDFlush = 1'b0;
    n_tests++; if (imem_req !== 1'b0 || IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL rr_drop req=%0b valid=%0b exp=0/0", imem_req, IF_ID_Valid); end
    step();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin n_fail++; $display("FAIL rr_launch req=%0b addr=%h exp=1/00005000", imem_req, imem_addr); end
    step();
    n_tests++; if (IF_ID_Valid !== 1'b1 || IF_ID_PC4 !== 32'h5004 || IF_ID_Instr !== 32'h5000) begin n_fail++; $display("FAIL rr_nokill valid=%0b pc4=%h instr=%h exp=1/00005004/00005000", IF_ID_Valid, IF_ID_PC4, IF_ID_Instr); end
  endtask

  task automatic test_reset_busy();
    mem_delay = 0; mem_rand = 1'b0;
    apply_reset();
    step(); step();
    mem_delay = 3; IF_IDWr = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_tests++; if (imem_req !== 1'b0 || IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'd0) begin n_fail++; $display("FAIL rs_busy req=%0b valid=%0b instr=%h exp=0/0/0", imem_req, IF_ID_Valid, IF_ID_Instr); end
    rst_n = 1'b1; IF_IDWr = 1'b1; force_rdy = 1'b1;
    step();
    force_rdy = 1'b0; mem_delay = 0;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000 || IF_ID_Valid !== 1'b0) begin n_fail++; $display("FAIL rs_restart req=%0b addr=%h valid=%0b exp=1/00003000/0", imem_req, imem_addr, IF_ID_Valid); end
    step();
    n_tests++; if (IF_ID_Valid !== 1'b1 || IF_ID_Instr !== 32'h3000 || IF_ID_PC4 !== 32'h3004) begin n_fail++; $display("FAIL rs_first valid=%0b instr=%h pc4=%h exp=1/00003000/00003004", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4); end
  endtask

  task automatic test_flush_hold();
    mem_delay = 0; mem_rand = 1'b0;
    apply_reset();
    step(); step(); step();
    PCWr = 1'b0; IF_IDWr = 1'b0;
    step();
    IF_IDFlush = 1'b1;
    step();
    IF_IDFlush = 1'b0;
    n_tests++; if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'd0 || IF_ID_PC4 !== 32'd0) begin n_fail++; $display("FAIL fh_flush valid=%0b instr=%h pc4=%h exp=0/0/0", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4); end
    PCWr = 1'b1; IF_IDWr = 1'b1;
    step();
    n_tests++; if (IF_ID_Valid !== 1'b1 || IF_ID_Instr !== 32'h3008 || IF_ID_PC4 !== 32'h300C) begin n_fail++; $display("FAIL fh_fb_kept valid=%0b instr=%h pc4=%h exp=1/00003008/0000300c", IF_ID_Valid, IF_ID_Instr, IF_ID_PC4); end
    step();
    n_tests++; if (IF_ID_PC4 !== 32'h3010 || IF_ID_Valid !== 1'b1) begin n_fail++; $display("FAIL fh_next pc4=%h valid=%0b exp=00003010/1", IF_ID_PC4, IF_ID_Valid); end
  endtask

  // Random controls and memory latency; reference is the architectural
  // instruction stream: consecutive addresses, restarting at each redirect.
  task automatic test_random();
    logic [31:0] exp_pc, old_pc4, old_instr, rpc;
    logic        old_valid, wr, fl, rd;
    int          loaded = 0;
    mem_delay = 2; mem_rand = 1'b1;
    apply_reset();
    exp_pc = 32'h3000;
    for (int c = 0; c < 3000; c++) begin
      PCWr     = ($urandom_range(0, 9) != 0);
      IF_IDWr  = ($urandom_range(0, 4) != 0);
      redirect = ($urandom_range(0, 24) == 0);
      IF_IDFlush  = redirect;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                : (($urandom & 32'h0000_FFFC) | 32'h0001_0000);
      old_pc4 = IF_ID_PC4; old_instr = IF_ID_Instr; old_valid = IF_ID_Valid;
      wr = IF_IDWr; fl = IF_IDFlush; rd = redirect; rpc = redirect_pc;
      step();
      if (prev_req && !prev_rdy) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin n_fail++; $display("FAIL rnd_addr_stable c=%0d req=%0b addr=%h exp=1/%h", c, imem_req, imem_addr, prev_addr); end
      end
      n_tests++;
      if (fl) begin
        if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'd0 || IF_ID_PC4 !== 32'd0) begin n_fail++; $display("FAIL rnd_flush c=%0d valid=%0b instr=%h pc4=%h exp=0/0/0", c, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4); end
      end else if (!wr) begin
        if (IF_ID_Valid !== old_valid || IF_ID_Instr !== old_instr || IF_ID_PC4 !== old_pc4) begin n_fail++; $display("FAIL rnd_hold c=%0d valid=%0b instr=%h pc4=%h exp=%0b/%h/%h", c, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4, old_valid, old_instr, old_pc4); end
      end else if (IF_ID_Valid === 1'b1) begin
        if (IF_ID_Instr !== exp_pc || IF_ID_PC4 !== exp_pc + 32'd4 || IF_ID_Rs !== exp_pc[25:21] || IF_ID_Rt !== exp_pc[20:16]) begin n_fail++; $display("FAIL rnd_order c=%0d instr=%h pc4=%h exp=%h/%h", c, IF_ID_Instr, IF_ID_PC4, exp_pc, exp_pc + 32'd4); end
        exp_pc = exp_pc + 32'd4;
        loaded++;
      end else begin
        if (IF_ID_Instr !== 32'd0 || IF_ID_PC4 !== old_pc4) begin n_fail++; $display("FAIL rnd_bubble c=%0d instr=%h pc4=%h exp=0/%h", c, IF_ID_Instr, IF_ID_PC4, old_pc4); end
      end
      if (rd) exp_pc = rpc;
    end
    n_tests++; if (loaded < 500) begin n_fail++; $display("FAIL rnd_progress loaded=%0d exp>=500", loaded); end
  endtask

  initial begin
    rst_n = 1'b0; PCWr = 1'b0; IF_IDWr = 1'b0; IF_IDFlush = 1'b0;
    redirect = 1'b0; redirect_pc = 32'd0; imem_rdy = 1'b0; imem_rdata = 32'd0;
    test_reset();
    test_stream();
    test_load_use();
    test_redirect_busy();
    test_redirect_rdy();
    test_reset_busy();
    test_flush_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and runs a request/ready handshake with instruction memory. A 1-entry fetch buffer absorbs memory responses while IF/ID is stalled.
- Honours PCWr/IF_IDWr from the load-use hazard unit and the branch/jump redirect from ID.
- Drives IF_ID_Rs/IF_ID_Rt back to the hazard unit.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- PCWr  in  1  from hazard unit; 0 = no new fetch may launch
- IF_IDWr  in  1  from hazard unit; 0 = IF/ID register holds
- IF_IDFlush  in  1  from ID; squash IF/ID contents (taken branch/jump)
- redirect  in  1  from ID; load PC with redirect_pc
- redirect_pc  in  32  branch/jump target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_rdy=0
- imem_rdy  in  1  response valid this cycle; only sampled while imem_req=1
- imem_rdata  in  32  instruction, valid with imem_rdy
- IF_ID_Instr  out  32  instruction to ID; 0 (sll nop) when invalid
- IF_ID_PC4  out  32  fetch address + 4
- IF_ID_Valid  out  1  IF/ID holds a real instruction
- IF_ID_Rs  out  5  IF_ID_Instr[25:21], combinational
- IF_ID_Rt  out  5  IF_ID_Instr[20:16], combinational

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=S_IDLE, fb_valid=0, kill=0, imem_req=0, IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0. Applies mid-transaction; any in-flight response is dropped.
- State S_IDLE: no outstanding request.
  - Launch when PCWr=1, redirect=0, and (fb_valid=0 or fb drained this cycle).
  - On launch: req_addr<=pc, pc<=pc+4, go S_BUSY.
- State S_BUSY: imem_req=1, imem_addr=req_addr.
  - On imem_rdy, response completes.
  - If kill=1 or redirect=1 this cycle: discard the response and clear kill.
  - Otherwise: if IF/ID loads this cycle and fb is empty, the response passes straight into IF/ID; else it is written to fb (fb_instr, fb_pc4=req_addr+4, fb_valid=1).
  - A back-to-back launch in the same cycle is permitted under the S_IDLE launch rule; otherwise go S_IDLE.
- Redirect (any state, independent of PCWr):
  - pc<=redirect_pc; fb_valid<=0.
  - If S_BUSY and imem_rdy=0: kill<=1, and the request stays asserted with the unchanged address until rdy.
  - Redirect blocks a launch in the same cycle; the new fetch starts the next cycle.
- IF/ID register, updated only when IF_IDWr=1:
  - IF_IDFlush=1: Instr=0, PC4=0, Valid=0. Flush wins over data. A flush while IF_IDWr=0 is still applied.
  - Else fb_valid: load fb, fb_valid<=0.
  - Else a direct response this cycle: load it.
  - Else bubble: Instr=0, Valid=0, PC4 holds.
- IF_IDWr=0 and no flush: all IF/ID outputs hold.
- Ordering: at most 2 instructions in flight (IF/ID + fb), so no further launch while fb_valid=1 and IF/ID is stalled.
- Minimum latency: imem_rdy in the launch+1 cycle gives the instruction in IF/ID at the following edge, i.e. 1 instruction per cycle sustained with a zero-wait memory.
- PC arithmetic: 32-bit wrap modulo 2^32. pc[1:0] is not checked.

Optional Feature:
- IF_PERF_CNT_EN
- Defined: adds outputs perf_fetched[31:0], counting accepted non-killed responses, and perf_squashed[31:0], counting killed/discarded responses plus IF/ID flushes of valid entries. Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory returning imem_rdata=addr: imem_addr runs 0x3000, 0x3004, 0x3008…, and IF_ID_PC4 runs 0x3004, 0x3008… with Valid=1 every cycle from cycle 3.
- Load-use stall: PCWr=IF_IDWr=0 for 1 cycle while an instruction at 0x3008 is in flight → it parks in fb, IF_ID holds the 0x3004 instruction, no launch occurs, and the next cycle IF_ID_PC4=0x300C with no instruction lost or duplicated.
- Redirect to 0x4000 with IF_IDFlush while S_BUSY with rdy delayed 3 cycles → imem_addr is stable for those 3 cycles, the response is discarded, the next imem_addr is 0x4000, and IF_ID_Valid=0 until the 0x4000 instruction arrives.
- Redirect in the same cycle as imem_rdy → response discarded, kill not set, next launch at redirect_pc.
- rst_n=0 while S_BUSY → next cycle imem_req=0 and IF_ID_Valid=0; a late imem_rdy is ignored; fetch restarts at 0x3000.
- IF_IDFlush with IF_IDWr=0 → IF_ID_Instr=0 and Valid=0 next cycle, while fb contents are preserved.
